car_rom_arbiter: RTL and testbench

Shares the single-port car sprite ROM (600×150 sheet, 16 orientations of 75×75, RGB444) between two car renderers (player 0 and player 1). Each renderer issues pixel reads as (degree, pixel_x, pixel_y). The block arbitrates round-robin and forms the ROM address through one shared `car_addr` instance. It pipelines the reads over the ROM's read latency and returns the pixel data tagged to the winning requester. It sits between the two renderers and the sprite block RAM.

---
 rtl/car_pkg.sv | 36 +++
 rtl/car_addr.sv | 28 ++
 rtl/car_rom_arbiter.sv | 108 ++++++++++
 tb/tb_car_rom_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared car sprite constants, tag type and orientation helper.
package car_pkg;

   localparam int unsigned SPRITE_W    = 75;
   localparam int unsigned SPRITE_H    = 75;
   localparam int unsigned SHEET_W     = 600;
   localparam int unsigned BANK_OFFSET = 45000;
   localparam int unsigned ROM_DEPTH   = 90000;

   localparam int unsigned DEG_W    = 9;
   localparam int unsigned XY_W     = 10;
   localparam int unsigned ADDR_W   = 17;
   localparam int unsigned ORIENT_W = 4;
   localparam int unsigned ORIENT_N = 16;
   localparam int unsigned DEG_FULL = 360;
   // 16 orientations over 360 degrees: orient = floor(2*degree/45)
   localparam int unsigned DEG_STEP2 = 45;

   localparam int unsigned CAR_DATA_W = 12;
   localparam logic [CAR_DATA_W-1:0] CAR_KEY_COLOR = 12'h0F0;

   typedef struct packed {
      logic valid;
      logic id;
      logic oor;
   } car_tag_t;

   // Headings 360..511 saturate to the last orientation.
   function automatic logic [ORIENT_W-1:0] car_orient(input logic [DEG_W-1:0] degree);
      logic [DEG_W:0] twice;
      twice = {degree, 1'b0};
      if (degree >= DEG_W'(DEG_FULL)) return ORIENT_W'(ORIENT_N - 1);
      return ORIENT_W'(twice / (DEG_W + 1)'(DEG_STEP2));
   endfunction

endpackage

// File: rtl/car_addr.sv
// Maps (degree, x, y) to a sprite-sheet ROM address; out-of-range reads map to 0.
module car_addr
   import car_pkg::*;
(
   input  logic [DEG_W-1:0]  degree,
   input  logic [XY_W-1:0]   x,
   input  logic [XY_W-1:0]   y,
   output logic [ADDR_W-1:0] addr_c,
   output logic              oor_c
);

   logic [ORIENT_W-1:0] orient;

   assign orient = car_orient(degree);

   // Top row holds orientations 0-7, bottom row (bank) holds 8-15.
   always_comb begin
      oor_c  = (x >= XY_W'(SPRITE_W)) || (y >= XY_W'(SPRITE_H));
      addr_c = '0;
      if (!oor_c) begin
         addr_c = (orient[3] ? ADDR_W'(BANK_OFFSET) : '0)
                + ADDR_W'(y) * ADDR_W'(SHEET_W)
                + ADDR_W'(orient[2:0]) * ADDR_W'(SPRITE_W)
                + ADDR_W'(x);
      end
   end

endmodule

// File: rtl/car_rom_arbiter.sv
// Round-robin arbiter sharing the car sprite ROM between two renderers.
// Optional feature macro: CAR_ARB_OPAQUE_EN adds the rd_opaque alpha output.
module car_rom_arbiter
   import car_pkg::*;
#(
   parameter int unsigned         ROM_LAT   = 1,
   parameter int unsigned         DATA_W    = CAR_DATA_W,
   parameter logic [DATA_W-1:0]   KEY_COLOR = DATA_W'(CAR_KEY_COLOR)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic [DEG_W-1:0]  p0_degree,
   input  logic [XY_W-1:0]   p0_x,
   input  logic [XY_W-1:0]   p0_y,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   input  logic              p1_req,
   input  logic [DEG_W-1:0]  p1_degree,
   input  logic [XY_W-1:0]   p1_x,
   input  logic [XY_W-1:0]   p1_y,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] rd_data
`ifdef CAR_ARB_OPAQUE_EN
   ,
   output logic              rd_opaque
`endif
);

   logic              last_q;
   logic              accept_c;
   logic              gid_c;
   logic [DEG_W-1:0]  deg_mux;
   logic [XY_W-1:0]   x_mux;
   logic [XY_W-1:0]   y_mux;
   logic [ADDR_W-1:0] addr_c;
   logic              oor_c;
   car_tag_t          tag_q [ROM_LAT+1];
   car_tag_t          ret_tag;
   logic [DATA_W-1:0] ret_data_c;

   // Grant: a lone requester wins; under contention the one not served last wins.
   assign p0_gnt   = p0_req && (!p1_req || last_q);
   assign p1_gnt   = p1_req && (!p0_req || !last_q);
   assign accept_c = p0_gnt || p1_gnt;
   assign gid_c    = p1_gnt;

   assign deg_mux = gid_c ? p1_degree : p0_degree;
   assign x_mux   = gid_c ? p1_x      : p0_x;
   assign y_mux   = gid_c ? p1_y      : p0_y;

   car_addr u_car_addr (
      .degree (deg_mux),
      .x      (x_mux),
      .y      (y_mux),
      .addr_c (addr_c),
      .oor_c  (oor_c)
   );

   // Round-robin pointer and ROM address register, updated only on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q   <= 1'b1;
         rom_addr <= '0;
      end else if (accept_c) begin
         last_q   <= gid_c;
         rom_addr <= addr_c;
      end
   end

   // Tag pipe tracks each read across the ROM latency; bubbles on idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: accept_c, id: gid_c, oor: oor_c};
         for (int unsigned i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign ret_tag    = tag_q[ROM_LAT];
   assign ret_data_c = ret_tag.oor ? KEY_COLOR : rom_data;

   // Return stage: register pixel and per-requester valid strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         rd_data   <= '0;
      end else begin
         p0_rvalid <= ret_tag.valid && !ret_tag.id;
         p1_rvalid <= ret_tag.valid &&  ret_tag.id;
         if (ret_tag.valid) rd_data <= ret_data_c;
      end
   end

`ifdef CAR_ARB_OPAQUE_EN
   // Alpha mask tracks the returned pixel against the key colour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_opaque <= 1'b0;
      else if (ret_tag.valid) rd_opaque <= (ret_data_c != KEY_COLOR);
   end
`endif

endmodule

// File: tb/tb_car_rom_arbiter.sv
// Directed bench for car_rom_arbiter (ROM_LAT=1 and ROM_LAT=2 instances).
module tb_car_rom_arbiter;

   localparam logic [11:0] KEY = 12'h0F0;

   logic        clk;
   logic        rst_n;

   logic        p0_req, p1_req;
   logic [8:0]  p0_degree, p1_degree;
   logic [9:0]  p0_x, p0_y, p1_x, p1_y;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [16:0] rom_addr;
   logic [11:0] rom_data, rd_data;

   logic        b_p0_req, b_p1_req;
   logic [8:0]  b_p0_degree, b_p1_degree;
   logic [9:0]  b_p0_x, b_p0_y, b_p1_x, b_p1_y;
   logic        b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid;
   logic [16:0] b_rom_addr;
   logic [11:0] b_rom_data, b_rd_data, b_rom_s1;
`ifdef CAR_ARB_OPAQUE_EN
   logic        rd_opaque, b_rd_opaque;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   car_rom_arbiter #(.ROM_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_degree(p0_degree), .p0_x(p0_x), .p0_y(p0_y),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p1_req(p1_req), .p1_degree(p1_degree), .p1_x(p1_x), .p1_y(p1_y),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .rom_addr(rom_addr), .rom_data(rom_data), .rd_data(rd_data)
`ifdef CAR_ARB_OPAQUE_EN
      , .rd_opaque(rd_opaque)
`endif
   );

   car_rom_arbiter #(.ROM_LAT(2)) dut_lat2 (
      .clk(clk), .rst_n(rst_n),
      .p0_req(b_p0_req), .p0_degree(b_p0_degree), .p0_x(b_p0_x), .p0_y(b_p0_y),
      .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid),
      .p1_req(b_p1_req), .p1_degree(b_p1_degree), .p1_x(b_p1_x), .p1_y(b_p1_y),
      .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid),
      .rom_addr(b_rom_addr), .rom_data(b_rom_data), .rd_data(b_rd_data)
`ifdef CAR_ARB_OPAQUE_EN
      , .rd_opaque(b_rd_opaque)
`endif
   );

   // ROM contents: a simple address hash.
   function automatic logic [11:0] rom_f(input logic [16:0] a);
      logic [16:0] t;
      t = a * 17'd13 + 17'd5;
      return t[11:0];
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM models with latency 1 and 2.
   always @(posedge clk) begin
      rom_data   <= rom_f(rom_addr);
      b_rom_s1   <= rom_f(b_rom_addr);
      b_rom_data <= b_rom_s1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated read by requester id, checked through to its return.
   task automatic do_read(input logic id, input logic [8:0] deg, input logic [9:0] x,
                          input logic [9:0] y, input logic [16:0] exp_addr, input logic exp_oor);
      logic [11:0] exp_data;
      if (!id) begin
         p0_req = 1'b1; p0_degree = deg; p0_x = x; p0_y = y;
      end else begin
         p1_req = 1'b1; p1_degree = deg; p1_x = x; p1_y = y;
      end
      #1;
      check("gnt0", 32'(p0_gnt), 32'(!id));
      check("gnt1", 32'(p1_gnt), 32'(id));
      tick();
      p0_req = 1'b0;
      p1_req = 1'b0;
      check("rom_addr", 32'(rom_addr), 32'(exp_addr));
      tick();
      check("rvalid_early", 32'({p0_rvalid, p1_rvalid}), 32'(0));
      tick();
      exp_data = exp_oor ? KEY : rom_f(exp_addr);
      check("rvalid0", 32'(p0_rvalid), 32'(!id));
      check("rvalid1", 32'(p1_rvalid), 32'(id));
      check("rd_data", 32'(rd_data), 32'(exp_data));
`ifdef CAR_ARB_OPAQUE_EN
      check("rd_opaque", 32'(rd_opaque), 32'(exp_data != KEY));
`endif
      tick();
      check("rvalid_drop", 32'({p0_rvalid, p1_rvalid}), 32'(0));
      check("rd_data_hold", 32'(rd_data), 32'(exp_data));
   endtask

   initial begin
      logic        exp_id;
      logic [16:0] exp_a;
      rst_n = 1'b0;
      p0_req = 0; p0_degree = 0; p0_x = 0; p0_y = 0;
      p1_req = 0; p1_degree = 0; p1_x = 0; p1_y = 0;
      b_p0_req = 0; b_p0_degree = 0; b_p0_x = 0; b_p0_y = 0;
      b_p1_req = 0; b_p1_degree = 0; b_p1_x = 0; b_p1_y = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_addr", 32'(rom_addr), 32'(0));
      check("rst_rd_data", 32'(rd_data), 32'(0));
      check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'(0));
      check("idle_gnt", 32'({p0_gnt, p1_gnt}), 32'(0));
      rst_n = 1'b1;
      tick();

      // Single reads, including bottom row, saturated heading and out-of-range.
      do_read(1'b0, 9'd0,   10'd0,  10'd0, 17'd0,     1'b0);
      do_read(1'b1, 9'd200, 10'd10, 10'd2, 17'd46210, 1'b0);
      do_read(1'b1, 9'd100, 10'd5,  10'd1, 17'd905,   1'b0);
      do_read(1'b0, 9'd0,   10'd75, 10'd0, 17'd0,     1'b1);
      do_read(1'b1, 9'd400, 10'd0,  10'd0, 17'd45525, 1'b0);
      do_read(1'b0, 9'd359, 10'd74, 10'd74, 17'd89999, 1'b0);
      do_read(1'b1, 9'd10,  10'd3,  10'd75, 17'd0,     1'b1);

      // Contention for 6 cycles: p0 (addr 1) and p1 (addr 2) alternate, p0 first.
      p0_req = 1; p0_degree = 0; p0_x = 1; p0_y = 0;
      p1_req = 1; p1_degree = 0; p1_x = 2; p1_y = 0;
      for (int k = 0; k < 8; k++) begin
         if (k < 6) begin
            #1;
            check("cont_gnt0", 32'(p0_gnt), 32'(k % 2 == 0));
            check("cont_gnt1", 32'(p1_gnt), 32'(k % 2 == 1));
         end
         tick();
         if (k == 5) begin
            p0_req = 0;
            p1_req = 0;
         end
         if (k < 6) check("cont_addr", 32'(rom_addr), 32'((k % 2 == 0) ? 1 : 2));
         if (k >= 2) begin
            exp_id = ((k - 2) % 2 == 1);
            exp_a  = exp_id ? 17'd2 : 17'd1;
            check("cont_rv0", 32'(p0_rvalid), 32'(!exp_id));
            check("cont_rv1", 32'(p1_rvalid), 32'(exp_id));
            check("cont_data", 32'(rd_data), 32'(rom_f(exp_a)));
         end
      end
      tick();

      // Reset with two reads in flight (p1 then p0, leaving p0 as last winner).
      p1_req = 1; p1_degree = 0; p1_x = 4; p1_y = 0;
      tick();
      p1_req = 0;
      p0_req = 1; p0_degree = 0; p0_x = 3; p0_y = 0;
      tick();
      p0_req = 0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_addr", 32'(rom_addr), 32'(0));
      check("mid_rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'(0));
      check("mid_rst_data", 32'(rd_data), 32'(0));
`ifdef CAR_ARB_OPAQUE_EN
      check("mid_rst_opaque", 32'(rd_opaque), 32'(0));
`endif
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'(0));
      end
      p0_req = 1; p1_req = 1;
      #1;
      check("post_rst_gnt0", 32'(p0_gnt), 32'(1));
      check("post_rst_gnt1", 32'(p1_gnt), 32'(0));
      tick();
      p0_req = 0; p1_req = 0;
      repeat (3) tick();

      // ROM_LAT=2: four back-to-back reads return 3 cycles after acceptance, no gaps.
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            b_p0_req = 1; b_p0_degree = 9'd100; b_p0_x = 10'(k); b_p0_y = 0;
         end else begin
            b_p0_req = 0;
         end
         tick();
         if (k >= 3 && k < 7) begin
            check("lat2_rvalid", 32'(b_p0_rvalid), 32'(1));
            check("lat2_data", 32'(b_rd_data), 32'(rom_f(17'(300 + k - 3))));
         end else begin
            check("lat2_idle", 32'(b_p0_rvalid), 32'(0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
